// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the decimal keypad entry block.
package digit_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int DEC_BASE  = 10;
  localparam int MAX_CODE  = 9;
  localparam int MAX_VALUE = 999;

  // Key codes above MAX_CODE are not decimal digits.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'(MAX_CODE);
  endfunction

endpackage

// File: rtl/digit_entry_mul10_add.sv
// Combinational decimal shift-in: result = acc*10 + code.
module mul10_add #(
  parameter int VW = 10
) (
  input  logic [VW-1:0] acc,
  input  logic [3:0]    code,
  output logic [VW-1:0] result
);

  // x10 built from two shifts so no multiplier is inferred.
  always_comb begin
    result = (acc << 3) + (acc << 1) + VW'(code);
  end

endmodule

// File: rtl/digit_entry.sv
// Keypad digit entry: accumulates up to NDIG decimal digits into a binary
// value, echoes them as BCD and hands the committed value off via valid/ready.
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int VW   = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  input  logic          key_enter,
  input  logic          key_clear,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [VW-1:0] out_value,
  output logic [3:0]    dig0,
  output logic [3:0]    dig1,
  output logic [3:0]    dig2,
  output logic [1:0]    ndigits,
  output logic          err,
  output logic          ovf
);

  localparam logic [1:0] NDIG_MAX = 2'(NDIG);

  state_t        state_q, state_d;
  logic [VW-1:0] acc_q, acc_d;
  logic [VW-1:0] out_value_q, out_value_d;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
  logic [1:0]    ndig_q, ndig_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [VW-1:0] acc_next;

  mul10_add #(.VW(VW)) u_mul10_add (
    .acc    (acc_q),
    .code   (key_code),
    .result (acc_next)
  );

  // Next-state logic; strobe priority is clear > enter > digit.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    dig0_d      = dig0_q;
    dig1_d      = dig1_q;
    dig2_d      = dig2_q;
    ndig_d      = ndig_q;
    err_d       = err_q;
    ovf_d       = 1'b0;

    if (key_clear) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      out_valid_d = 1'b0;
      dig0_d      = '0;
      dig1_d      = '0;
      dig2_d      = '0;
      ndig_d      = '0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ENTRY: begin
          if (key_enter) begin
            // An empty entry has nothing to commit.
            if (state_q == ST_ENTRY) begin
              state_d     = ST_HOLD;
              out_value_d = acc_q;
              out_valid_d = 1'b1;
            end
          end else if (key_valid) begin
            if (!is_digit(key_code)) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end else if (ndig_q == NDIG_MAX) begin
              ovf_d = 1'b1;
            end else begin
              state_d = ST_ENTRY;
              acc_d   = acc_next;
              dig2_d  = dig1_q;
              dig1_d  = dig0_q;
              dig0_d  = key_code;
              ndig_d  = ndig_q + 2'd1;
            end
          end
        end
        ST_HOLD: begin
          if (out_valid_q && out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            acc_d       = '0;
            dig0_d      = '0;
            dig1_d      = '0;
            dig2_d      = '0;
            ndig_d      = '0;
          end
        end
        ST_ERROR: begin
          // Only clear leaves the error state.
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      dig0_q      <= '0;
      dig1_q      <= '0;
      dig2_q      <= '0;
      ndig_q      <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
      dig2_q      <= dig2_d;
      ndig_q      <= ndig_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign dig0      = dig0_q;
  assign dig1      = dig1_q;
  assign dig2      = dig2_q;
  assign ndigits   = ndig_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with hand-computed expectations.
module tb_digit_entry;

  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_valid, key_enter, key_clear, out_ready;
  logic [3:0]    key_code;
  logic          out_valid;
  logic [VW-1:0] out_value;
  logic [3:0]    dig0, dig1, dig2;
  logic [1:0]    ndigits;
  logic          err, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  digit_entry #(.NDIG(3), .VW(VW)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_enter (key_enter),
    .key_clear (key_clear),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .dig0      (dig0),
    .dig1      (dig1),
    .dig2      (dig2),
    .ndigits   (ndigits),
    .err       (err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Each strobe is driven for exactly one rising edge; on return we sit at the
  // following falling edge with the registered result visible.
  task automatic key(input int code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(code);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic enter();
    @(negedge clk);
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    key_code  = 4'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_value", int'(out_value), 0);
    check("rst_ndig", int'(ndigits), 0);
    check("rst_err", int'(err), 0);
    reset = 1'b1;

    // 4,0,2 then enter with ready high
    key(4); key(0); key(2);
    check("s1_dig2", int'(dig2), 4);
    check("s1_dig1", int'(dig1), 0);
    check("s1_dig0", int'(dig0), 2);
    check("s1_ndig", int'(ndigits), 3);
    enter();
    check("s1_valid", int'(out_valid), 1);
    check("s1_value", int'(out_value), 402);
    @(negedge clk);
    check("s1_valid_drop", int'(out_valid), 0);
    check("s1_ndig_idle", int'(ndigits), 0);
    check("s1_dig0_idle", int'(dig0), 0);
    check("s1_dig2_idle", int'(dig2), 0);

    // overflow on the fourth digit
    key(1); key(2); key(3);
    check("s2_ovf_before", int'(ovf), 0);
    key(4);
    check("s2_ovf_pulse", int'(ovf), 1);
    check("s2_dig0", int'(dig0), 3);
    check("s2_ndig", int'(ndigits), 3);
    @(negedge clk);
    check("s2_ovf_end", int'(ovf), 0);
    enter();
    check("s2_valid", int'(out_valid), 1);
    check("s2_value", int'(out_value), 123);
    @(negedge clk);
    check("s2_valid_drop", int'(out_valid), 0);

    // enter with no digits is ignored
    enter();
    check("idle_enter", int'(out_valid), 0);

    // illegal code locks into error
    key(5);
    key(12);
    check("s3_err", int'(err), 1);
    key(3);
    check("s3_err_held", int'(err), 1);
    check("s3_dig0_frozen", int'(dig0), 5);
    check("s3_ndig_frozen", int'(ndigits), 1);
    enter();
    check("s3_no_valid", int'(out_valid), 0);
    clear();
    check("s3_err_clr", int'(err), 0);
    check("s3_ndig_clr", int'(ndigits), 0);
    check("s3_dig0_clr", int'(dig0), 0);
    key(8);
    check("s3_accepts", int'(dig0), 8);
    clear();

    // back-pressure: held value stays put
    out_ready = 1'b0;
    key(9); key(9); key(9);
    enter();
    for (int i = 0; i < 5; i++) begin
      check("s4_valid_hold", int'(out_valid), 1);
      check("s4_value_hold", int'(out_value), 999);
      @(negedge clk);
    end
    key(1);  // digits ignored while holding
    check("s4_dig0_kept", int'(dig0), 9);
    out_ready = 1'b1;
    @(negedge clk);
    check("s4_accepted", int'(out_valid), 0);
    check("s4_ndig_idle", int'(ndigits), 0);

    // clear outranks enter
    key(7); key(8);
    @(negedge clk);
    key_enter = 1'b1;
    key_clear = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    key_clear = 1'b0;
    check("s5_no_valid", int'(out_valid), 0);
    check("s5_ndig", int'(ndigits), 0);
    @(negedge clk);
    check("s5_still_idle", int'(out_valid), 0);

    // asynchronous reset while holding
    out_ready = 1'b0;
    key(3); key(1);
    enter();
    check("s6_valid_pre", int'(out_valid), 1);
    check("s6_value_pre", int'(out_value), 31);
    #2 reset = 1'b0;
    #1;
    check("s6_valid_rst", int'(out_valid), 0);
    check("s6_value_rst", int'(out_value), 0);
    check("s6_dig0_rst", int'(dig0), 0);
    check("s6_ndig_rst", int'(ndigits), 0);
    out_ready = 1'b1;
    @(negedge clk);
    // strobe on the very first edge after release
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd6;
    @(negedge clk);
    key_valid = 1'b0;
    check("s6_first_edge_dig0", int'(dig0), 6);
    check("s6_first_edge_ndig", int'(ndigits), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 The block SHALL have parameter NDIG, default 3, giving the maximum decimal digits accepted per entry.
REQ-002 The block SHALL have parameter VW, default 10, giving the output value width; 10^NDIG-1 SHALL fit in VW bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-006 The block SHALL have port key_code, input, 4 bits: keyed decimal digit; 0-9 are legal, 10-15 are illegal.
REQ-007 The block SHALL have port key_enter, input, 1 bit: one-cycle strobe that commits the entry.
REQ-008 The block SHALL have port key_clear, input, 1 bit: one-cycle strobe that aborts the entry.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_value.
REQ-010 The block SHALL have port out_valid, output, 1 bit: committed value available.
REQ-011 The block SHALL have port out_value, output, VW bits: committed binary value.
REQ-012 The block SHALL have ports dig0, dig1, dig2, output, 4 bits each: BCD echo of entered digits for the 7-seg decoders; dig0 is the rightmost digit.
REQ-013 The block SHALL have port ndigits, output, 2 bits: count of digits in the current entry.
REQ-014 The block SHALL have port err, output, 1 bit: an illegal key code has been received.
REQ-015 The block SHALL have port ovf, output, 1 bit: one-cycle pulse when a digit is dropped.

Function
REQ-016 The block SHALL implement FSM states IDLE (no digits), ENTRY (1..NDIG digits), HOLD (out_valid asserted) and ERROR.
REQ-017 Key precedence in a cycle SHALL be key_clear > key_enter > key_valid; lower-priority strobes in the same cycle are dropped.
REQ-018 key_clear SHALL, from any state, return the FSM to IDLE on the next edge with acc=0, ndigits=0, dig0..2=0, out_valid=0 and err=0.
REQ-019 In IDLE or ENTRY, key_valid with code 0-9 and ndigits<NDIG SHALL update acc to acc*10+code, shift dig2<=dig1, dig1<=dig0, dig0<=code, increment ndigits and move to ENTRY, all visible one cycle later.
REQ-020 In IDLE or ENTRY, key_valid with code 0-9 and ndigits==NDIG SHALL leave the state unchanged and pulse ovf for exactly one cycle.
REQ-021 key_valid with code 10-15 in IDLE or ENTRY SHALL move the FSM to ERROR with err=1 held; in ERROR only key_clear has effect.
REQ-022 key_enter in ENTRY SHALL load out_value=acc and assert out_valid on the next cycle, moving to HOLD.
REQ-023 key_enter in IDLE SHALL be ignored; no zero-digit commit occurs.
REQ-024 In HOLD, out_valid and out_value SHALL remain stable until the cycle with out_valid&out_ready; on the following cycle out_valid=0, acc, ndigits and dig0..2 are 0, and the FSM is in IDLE.
REQ-025 In HOLD, key_valid and key_enter SHALL be ignored.
REQ-026 out_ready SHALL be ignored while out_valid=0.
REQ-027 acc*10 SHALL be computed as (acc<<3)+(acc<<1) at VW bits; no wrap is possible, and the maximum value is 999.
REQ-028 A leading zero SHALL count as a digit, so keys 0,0,7 give ndigits=3 and value 7.

Reset
REQ-029 While reset=0, the FSM SHALL be in IDLE; acc, out_value, dig0..2 and ndigits SHALL be 0; out_valid, err and ovf SHALL be 0.
REQ-030 Reset assertion SHALL take effect asynchronously, mid-entry or in HOLD, discarding any pending value.
REQ-031 Strobes on the first clock edge after reset deassertion SHALL be processed normally.

Structure
REQ-032 Package digit_entry_pkg SHALL hold the state enum, DEC_BASE=10, MAX_CODE=9 and MAX_VALUE=999.
REQ-033 The design SHALL contain one combinational sub-module, mul10_add (acc, code -> acc*10+code), and the FSM and registers SHALL be in digit_entry.

Verification
REQ-034 The bench SHALL check: keys 4,0,2, enter, out_ready=1 -> out_value=402, out_valid for one cycle, dig2..0=4,0,2, then IDLE.
REQ-035 The bench SHALL check: keys 1,2,3,4 -> ovf pulses once on key 4, out_value=123 after enter, and dig0=3.
REQ-036 The bench SHALL check: key 5, key code 12, key 3, enter -> err=1 held, no out_valid, then clear -> err=0, IDLE.
REQ-037 The bench SHALL check: keys 9,9,9, enter, out_ready=0 for 5 cycles -> out_valid=1 and out_value=999 stable, then ready -> accepted.
REQ-038 The bench SHALL check: key_enter and key_clear in the same cycle during ENTRY -> IDLE with no out_valid.
REQ-039 The bench SHALL check: reset=0 asserted mid-cycle during HOLD -> immediate out_valid=0 and all outputs 0.
